// File: rtl/tcore_param.sv
// Shared lowX line-refill bus types and widths used by the caches and the memory responder.
package tcore_param;

  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  localparam int WORDS_PER_LINE = BLK_SIZE / XLEN;
  localparam int LINE_OFFSET    = $clog2(BLK_SIZE / 8);
  localparam int LANE_W         = LINE_OFFSET - 2;

  // rw = 1 is a write, rw = 0 a read; ready is the requester accepting a response.
  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic                rw;
    logic                uncached;
    logic [BLK_SIZE-1:0] data;
  } lowx_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowx_res_t;

  function automatic logic [WORDS_PER_LINE-1:0] lane_mask(input logic [LANE_W-1:0] lane);
    return WORDS_PER_LINE'(1) << lane;
  endfunction

endpackage

// File: rtl/lowx_mem_responder_if.sv
// lowX request/response bundle; master is the cache side, slave the memory responder.
interface lowx_mem_responder_if;
  import tcore_param::*;

  lowx_req_t req;
  lowx_res_t res;

  modport master (output req, input res);
  modport slave  (input req, output res);

endinterface

// File: rtl/lowx_line_ram.sv
// Single-port line store with per-word write enables and a registered read port,
// kept in its own module so it can be replaced by a vendor block RAM.
module lowx_line_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 128,
  parameter int WORD  = 32
) (
  input  logic                      clk,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [WIDTH/WORD-1:0]     we,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata
);

  localparam int WORDS = WIDTH / WORD;

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and the read register have no reset so the block maps onto
  // block RAM; contents are undefined until written.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // reader of rdata/mem sees the pre-edge value regardless of process order.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int w = 0; w < WORDS; w++) begin
      if (we[w]) begin
        mem[addr][w*WORD +: WORD] <= wdata[w*WORD +: WORD];
      end
    end
  end

endmodule

// File: rtl/lowx_mem_responder.sv
// lowX memory responder: one line request at a time, fixed (or, with
// LOWX_RAND_LATENCY_EN defined, LFSR-jittered) latency, full-line response.
module lowx_mem_responder
  import tcore_param::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lowx_mem_responder_if.slave   lx
);

  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int IDX_HI = LINE_OFFSET + IDX_W - 1;
  localparam int CNT_W  = $clog2(LATENCY + 4);

  if (LATENCY < 1) begin : g_bad_latency
    $error("lowx_mem_responder: LATENCY must be >= 1");
  end
  if ((DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_bad_depth
    $error("lowx_mem_responder: DEPTH_LINES must be a power of 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_load;
  logic                      accept, do_access;

  logic [IDX_W-1:0]          idx_q, ram_idx;
  logic [LANE_W-1:0]         lane_q;
  logic                      rw_q, unc_q;
  logic [BLK_SIZE-1:0]       wdata_q, ram_rdata, merged, data_q;
  logic [WORDS_PER_LINE-1:0] word_we;

  // Upper address bits alias onto the same lines; the byte offset within a word is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lx.req.addr[XLEN-1:IDX_HI+1], lx.req.addr[1:0]};

`ifdef LOWX_RAND_LATENCY_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; the low bits are sampled before the accept advances it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lx.req.valid) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = cnt_load;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (lx.req.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      lane_q  <= '0;
      rw_q    <= 1'b0;
      unc_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= lx.req.addr[IDX_HI:LINE_OFFSET];
      lane_q  <= lx.req.addr[LINE_OFFSET-1:2];
      rw_q    <= lx.req.rw;
      unc_q   <= lx.req.uncached;
      wdata_q <= lx.req.data;
    end
  end

  // While idle the RAM reads the incoming line, so its registered output is
  // valid from the first WAIT cycle even when LATENCY is 1.
  assign ram_idx = (state_q == IDLE) ? lx.req.addr[IDX_HI:LINE_OFFSET] : idx_q;

  always_comb begin
    word_we = '0;
    if (do_access && rw_q) begin
      word_we = unc_q ? lane_mask(lane_q) : '1;
    end
  end

  lowx_line_ram #(
    .DEPTH (DEPTH_LINES),
    .WIDTH (BLK_SIZE),
    .WORD  (XLEN)
  ) u_line_ram (
    .clk   (clk_i),
    .addr  (ram_idx),
    .we    (word_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The response is the line as it stands after this access, written words included.
  always_comb begin
    merged = ram_rdata;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (word_we[w]) begin
        merged[w*XLEN +: XLEN] = wdata_q[w*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (do_access) begin
      data_q <= merged;
    end
  end

  assign lx.res = '{valid: (state_q == RESP), ready: (state_q == IDLE), data: data_q};

endmodule
